// File: rtl/keyscan_pkg.sv
// Shared types and the keypad layout map for the matrix keypad scanner.
package keyscan_pkg;

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_PRESSED
   } scan_state_t;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   // 4x3 pads use the phone layout; any other geometry reports the raw index.
   function automatic logic [3:0] key_code(input int r, input int c, input int rows, input int cols);
      int idx;
      idx = r * cols + c;
      if (rows == 4 && cols == 3) begin
         if (r < 3) return 4'(idx + 1);
         if (c == 0) return KEY_STAR;
         if (c == 1) return 4'd0;
         return KEY_HASH;
      end
      return 4'(idx);
   endfunction

endpackage

// File: rtl/rows_sync.sv
// Two-flop synchroniser for the raw keypad row lines, cleared by the async reset.
module rows_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keyscan_matrix.sv
// Matrix keypad scanner: column strobing, press/release debounce, single-key decode,
// digit entry buffer and the level buttons on the star and hash keys.
//
//   state      | meaning
//   S_SCAN     | strobing columns, waiting for exactly one active row
//   S_DEBOUNCE | column frozen, counting identical samples of the latched row
//   S_PRESSED  | key accepted, counting all-zero samples until release
module keyscan_matrix
   import keyscan_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 3,
   parameter int DEPTH    = 4,
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift,
   input  logic [ROWS-1:0]    rows,
   output logic [COLS-1:0]    columns,
   output logic [3:0]         key,
   output logic               key_valid,
   output logic [4*DEPTH-1:0] key_buffer,
   output logic               time_button,
   output logic               alarm_button
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int BW = 4 * DEPTH;

   scan_state_t   state, state_n;
   logic [SW-1:0] div;
   logic          tick;
   logic [CW-1:0] col, col_n, col_adv;
   logic [RW-1:0] row, row_n, hot_row;
   logic [DW-1:0] cnt, cnt_n, rel, rel_n;
   logic [ROWS-1:0] sync_rows;
   logic          one_hot;
   logic          accept;
   logic [3:0]    code;

   rows_sync #(.W(ROWS)) u_rows_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (sync_rows)
   );

   assign tick    = (div == SW'(SCAN_DIV - 1));
   assign one_hot = (sync_rows != '0) && ((sync_rows & (sync_rows - ROWS'(1))) == '0);
   assign col_adv = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
   assign columns = COLS'(1) << col;
   assign code    = key_code(int'(row_n), int'(col), ROWS, COLS);

   // The buttons follow the held key directly, so they drop on the edge leaving S_PRESSED.
   assign time_button  = (state == S_PRESSED) && (key == KEY_STAR);
   assign alarm_button = (state == S_PRESSED) && (key == KEY_HASH);

   always_comb begin
      hot_row = '0;
      for (int i = 0; i < ROWS; i++)
         if (sync_rows[i]) hot_row = RW'(i);
   end

   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      cnt_n   = cnt;
      rel_n   = rel;
      accept  = 1'b0;
      if (tick) begin
         unique case (state)
            S_SCAN: begin
               if (one_hot) begin
                  row_n = hot_row;
                  cnt_n = DW'(1);
                  if (DEBOUNCE == 1) begin
                     state_n = S_PRESSED;
                     accept  = 1'b1;
                  end else begin
                     state_n = S_DEBOUNCE;
                  end
               end else begin
                  col_n = col_adv;
               end
            end
            S_DEBOUNCE: begin
               if (sync_rows == (ROWS'(1) << row)) begin
                  cnt_n = cnt + DW'(1);
                  if (cnt + DW'(1) == DW'(DEBOUNCE)) begin
                     state_n = S_PRESSED;
                     accept  = 1'b1;
                  end
               end else begin
                  state_n = S_SCAN;
                  col_n   = col_adv;
               end
            end
            S_PRESSED: begin
               if (sync_rows == '0) begin
                  if (rel + DW'(1) == DW'(DEBOUNCE)) begin
                     state_n = S_SCAN;
                     col_n   = col_adv;
                     rel_n   = '0;
                  end else begin
                     rel_n = rel + DW'(1);
                  end
               end else begin
                  rel_n = '0;
               end
            end
            default: state_n = S_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_SCAN;
         div   <= '0;
         col   <= '0;
         row   <= '0;
         cnt   <= '0;
         rel   <= '0;
      end else begin
         state <= state_n;
         div   <= tick ? '0 : div + SW'(1);
         col   <= col_n;
         row   <= row_n;
         cnt   <= cnt_n;
         rel   <= rel_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key        <= '0;
         key_valid  <= 1'b0;
         key_buffer <= '0;
      end else begin
         key_valid <= accept;
         if (accept) begin
            key <= code;
            if (code < 4'd10) begin
               if (shift) begin
                  for (int i = DEPTH - 1; i > 0; i--)
                     key_buffer[4*i +: 4] <= key_buffer[4*(i-1) +: 4];
                  key_buffer[3:0] <= code;
               end else begin
                  key_buffer <= BW'(code);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_keyscan_matrix.sv
// Bench for keyscan_matrix: a physical 4x3 keypad driven by a pressed-key mask,
// a tick-level reference model checked every clock, plus table and hand sequences.
module tb_keyscan_matrix;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        shift = 1'b0;
   logic [3:0]  rows;
   logic [2:0]  columns;
   logic [3:0]  key;
   logic        key_valid;
   logic [15:0] key_buffer;
   logic        time_button;
   logic        alarm_button;
   logic [11:0] pressed = '0;

   int total = 0;
   int bad = 0;
   int pulses = 0;

   keyscan_matrix dut (
      .clk          (clk),
      .reset        (reset),
      .shift        (shift),
      .rows         (rows),
      .columns      (columns),
      .key          (key),
      .key_valid    (key_valid),
      .key_buffer   (key_buffer),
      .time_button  (time_button),
      .alarm_button (alarm_button)
   );

   always #5 clk = ~clk;

   // Key index r*3+c closes row r whenever column c is being driven.
   always_comb begin
      rows = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r*3+c] && columns[c]) rows[r] = 1'b1;
   end

   // Reference model: works on the per-tick samples the scanner is allowed to see.
   int          layout [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
   int          m_col, m_div, m_zero;
   bit          m_hold;
   logic [3:0]  m_key;
   logic        m_kv;
   logic [15:0] m_buf;
   logic [3:0]  r1, r2;
   logic [3:0]  run [$];

   task automatic model_reset();
      m_col = 0; m_div = 0; m_zero = 0; m_hold = 0;
      m_key = '0; m_kv = 1'b0; m_buf = '0; r1 = '0; r2 = '0;
      run.delete();
   endtask

   task automatic model_accept(input logic sh);
      int r;
      int code;
      r = 0;
      for (int i = 0; i < 4; i++) if (run[0][i]) r = i;
      code = layout[r*3 + m_col];
      m_key = 4'(code);
      m_kv = 1'b1;
      m_hold = 1;
      m_zero = 0;
      run.delete();
      if (code < 10) m_buf = sh ? {m_buf[11:0], 4'(code)} : {12'h000, 4'(code)};
   endtask

   task automatic model_edge(input logic [3:0] pre, input logic sh);
      logic [3:0] s;
      s = r2;
      m_kv = 1'b0;
      if (m_div == 3) begin
         if (!m_hold) begin
            if (run.size() == 0) begin
               if ($countones(s) == 1) run.push_back(s);
               else m_col = (m_col + 1) % 3;
            end else if (s == run[0]) begin
               run.push_back(s);
            end else begin
               run.delete();
               m_col = (m_col + 1) % 3;
            end
            if (run.size() == 3) model_accept(sh);
         end else begin
            m_zero = (s == 0) ? m_zero + 1 : 0;
            if (m_zero == 3) begin
               m_hold = 0;
               m_zero = 0;
               m_col = (m_col + 1) % 3;
            end
         end
      end
      m_div = (m_div + 1) % 4;
      r2 = r1;
      r1 = pre;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({columns, key, key_valid, key_buffer, time_button, alarm_button});
   endfunction

   task automatic step();
      logic [3:0] pre;
      logic [31:0] exp;
      @(negedge clk);
      pre = rows;
      @(posedge clk);
      model_edge(pre, shift);
      #1;
      exp = 32'({3'(3'b001 << m_col), m_key, m_kv, m_buf,
                 m_hold && (m_key == 4'd10), m_hold && (m_key == 4'd11)});
      check("cycle", outs(), exp);
      if (key_valid) pulses++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic async_reset(input string name);
      reset = 1'b0;
      #1;
      check(name, outs(), 32'({3'b001, 4'h0, 1'b0, 16'h0000, 2'b00}));
      model_reset();
      pressed = '0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   // Leaves the bench just after the edge that moves the scan onto column 0.
   task automatic align_col0(input string name);
      int n;
      n = 0;
      while (columns != 3'b100 && n < 40) begin step(); n++; end
      while (columns != 3'b001 && n < 40) begin step(); n++; end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL %s: column 0 not reached within 40 clocks", name);
      end
   endtask

   typedef struct {
      logic [11:0] keys;
      logic        sh;
      logic [3:0]  k;
      logic [15:0] buff;
      int          npulse;
      logic [1:0]  btn;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{12'h1 << 3,  1'b0, 4'd4,  16'h0004, 1, 2'b00};
      vt[1] = '{12'h1 << 7,  1'b1, 4'd8,  16'h0048, 1, 2'b00};
      vt[2] = '{12'h1 << 1,  1'b1, 4'd2,  16'h0482, 1, 2'b00};
      vt[3] = '{12'h1 << 0,  1'b1, 4'd1,  16'h4821, 1, 2'b00};
      vt[4] = '{12'h1 << 4,  1'b1, 4'd5,  16'h8215, 1, 2'b00};
      vt[5] = '{12'h1 << 9,  1'b0, 4'd10, 16'h8215, 1, 2'b01};
      vt[6] = '{12'h1 << 11, 1'b0, 4'd11, 16'h8215, 1, 2'b10};
      vt[7] = '{12'h009,     1'b1, 4'd11, 16'h8215, 0, 2'b00};

      #2;
      async_reset("reset_values");

      // Idle: column steps every 4 clocks, everything else quiet.
      for (int k = 1; k <= 12; k++) begin
         step();
         check("idle_columns", 32'(columns),
               (k < 4) ? 32'd1 : (k < 8) ? 32'd2 : (k < 12) ? 32'd4 : 32'd1);
      end

      foreach (vt[i]) begin
         pulses = 0;
         shift = vt[i].sh;
         pressed = vt[i].keys;
         steps(80);
         check("held_buttons", 32'({alarm_button, time_button}), 32'(vt[i].btn));
         pressed = '0;
         steps(40);
         check("vec_pulses", 32'(pulses), 32'(vt[i].npulse));
         check("vec_key", 32'(key), 32'(vt[i].k));
         check("vec_buffer", 32'(key_buffer), 32'(vt[i].buff));
         check("released_buttons", 32'({alarm_button, time_button}), 32'd0);
      end

      // Bounce: exactly two matching ticks, then the row drops.
      align_col0("bounce_align");
      pulses = 0;
      pressed = 12'h1 << 3;
      steps(8);
      pressed = '0;
      steps(4);
      check("bounce_resume_col", 32'(columns), 32'd2);
      steps(36);
      check("bounce_pulses", 32'(pulses), 32'd0);
      check("bounce_key", 32'(key), 32'd11);
      check("bounce_buffer", 32'(key_buffer), 32'h8215);

      // Rollover: a second key while one is held is ignored.
      shift = 1'b1;
      pulses = 0;
      pressed = 12'h1 << 3;
      steps(60);
      pressed = pressed | (12'h1 << 5);
      steps(60);
      check("rollover_pulses", 32'(pulses), 32'd1);
      check("rollover_key", 32'(key), 32'd4);
      pressed = '0;
      steps(40);
      pressed = 12'h1 << 5;
      steps(60);
      pressed = '0;
      steps(40);
      check("second_key_pulses", 32'(pulses), 32'd2);
      check("second_key", 32'(key), 32'd6);
      check("second_buffer", 32'(key_buffer), 32'h1546);

      // Reset in the middle of debounce.
      align_col0("rst_deb_align");
      pressed = 12'h1 << 3;
      steps(5);
      async_reset("rst_debounce");
      pulses = 0;
      steps(30);
      check("rst_debounce_pulses", 32'(pulses), 32'd0);

      // Reset while a key is held.
      pressed = 12'h1 << 9;
      begin
         int n;
         n = 0;
         while (!key_valid && n < 100) begin step(); n++; end
         check("press_seen", 32'(key_valid), 32'd1);
      end
      steps(6);
      async_reset("rst_pressed");
      pulses = 0;
      steps(40);
      check("rst_pressed_pulses", 32'(pulses), 32'd0);

      // Random keypad activity against the reference model.
      for (int it = 0; it < 40; it++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 6) pressed = 12'h1 << $urandom_range(0, 11);
         else if (sel < 8) pressed = (12'h1 << $urandom_range(0, 11)) | (12'h1 << $urandom_range(0, 11));
         else pressed = '0;
         shift = 1'($urandom_range(0, 1));
         steps($urandom_range(1, 70));
         pressed = '0;
         steps($urandom_range(1, 30));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keyscan_matrix.md
# keyscan_matrix

Parametrised matrix-keypad scanner for the clock design: drives one-hot column strobes, samples synchronised rows, debounces press and release, and decodes a single key at a time. Decoded digits feed a DEPTH-digit entry buffer, newest digit in slot 0. The `*` and `#` keys act as the debounced level buttons `time_button` and `alarm_button`. Replaces the fixed 4x3, 4-digit scanner and adds configurable geometry, debounce, and dwell, plus a key-valid strobe.

## Interface
- `ROWS`, 4, keypad row count.
- `COLS`, 3, keypad column count; drives the `columns` width.
- `DEPTH`, 4, digits in the entry buffer.
- `SCAN_DIV`, 4, clocks per column dwell; must be ≥3.
- `DEBOUNCE`, 3, consecutive identical samples required for press and for release; must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `shift`  in  1  on a digit press: 1 shifts into the buffer; 0 clears the buffer and loads the digit into slot 0.
- `rows`  in  ROWS  raw keypad rows, active-high, asynchronous.
- `columns`  out  COLS  one-hot, active-high column drive.
- `key`  out  4  code of the last accepted key.
- `key_valid`  out  1  one-clock pulse per accepted press.
- `key_buffer`  out  4*DEPTH  digit slots; bits [3:0] hold slot 0, the newest.
- `time_button`  out  1  high while `*` is in PRESSED.
- `alarm_button`  out  1  high while `#` is in PRESSED.

## Operation
- `rows` pass through a 2-flop synchroniser before any use.
- Free-running divider counts 0..SCAN_DIV-1. A sample tick occurs when the count is SCAN_DIV-1; only sample ticks evaluate `rows`.
- Key index is r*COLS+c.
- Default geometry uses the phone layout: 1 2 3 / 4 5 6 / 7 8 9 / `*` 0 `#`.
  - `*` = code 10; `#` = code 11.
  - Any other geometry uses the index as the code, truncated to 4 bits.
- FSM states: SCAN, DEBOUNCE, PRESSED.
  - SCAN, on tick:
    - Synced rows exactly one-hot: latch row r and column c, set count to 1, go to DEBOUNCE. Columns freeze.
    - Otherwise, including zero or multi-hot rows: advance the column, wrapping from COLS-1 to 0.
  - DEBOUNCE, on tick:
    - Rows equal the latched row: increment count. When count reaches DEBOUNCE, go to PRESSED and accept the key.
    - Any mismatch: go to SCAN and advance the column. No output changes.
  - PRESSED, on tick:
    - Rows == 0: increment the release count.
    - Rows nonzero: clear the release count.
    - Release count reaches DEBOUNCE: go to SCAN and advance the column.
- Accepting a key does the following:
  - Register `key` with the code and pulse `key_valid` for one clock.
  - Digit codes 0-9, `shift`=1: shift slot i into slot i+1 and load the digit into slot 0. The oldest digit is dropped.
  - Digit codes 0-9, `shift`=0: zero all slots and load the digit into slot 0.
  - Codes 10/11: buffer unchanged. `time_button` / `alarm_button` goes high.
- While PRESSED, other keys are ignored, including keys in other columns. One key at a time, no rollover.
- `shift` is sampled only at the accept edge.

## Timing
- Reset values:
  - `columns` = 1 (column 0).
  - `key`, `key_buffer` = 0.
  - `key_valid`, `time_button`, `alarm_button` = 0.
  - FSM in SCAN; divider, debounce, and release counts = 0.
  - The synchroniser flops are also cleared.
- Reset is asynchronous and may assert in any state. Outputs reach reset values without waiting for a clock, and no pulse is emitted afterwards.
- The column changes on the same edge as the tick that advances it.
- `key_valid` and `key` update on the edge of the DEBOUNCE-th matching tick. With defaults, the minimum press-to-valid time is 2 (sync) plus a 4-clock dwell alignment plus 2×4 clocks.
- `time_button` / `alarm_button` rise on the accept edge and fall on the edge that leaves PRESSED.
- Rows that change between ticks are not seen. Only tick samples count.

## Structure
- Package `keyscan_pkg` holds:
  - the state enum;
  - constants `KEY_STAR`=10 and `KEY_HASH`=11;
  - function `key_code(r, c, ROWS, COLS)` implementing the layout map.
- Sub-module `rows_sync`: ROWS-wide 2-flop synchroniser with async active-low clear.
- Everything else lives in `keyscan_matrix`.

## Test plan
All scenarios use default parameters.
1. Reset, then idle -> `columns` cycles 001→010→100→001 with 4 clocks per step; all other outputs stay 0.
2. Digit entry:
   - Press `4` (row 1, col 0) with `shift`=0 -> `key`=4, one `key_valid` pulse, buffer [0][0][0][4].
   - Then `8`, `2`, `1` with `shift`=1 -> [4][8][2][1].
   - Then `5` -> [8][2][1][5].
3. Bounce: row high for 2 ticks, then low -> no `key_valid`, buffer unchanged, column scan resumes.
4. Hold `*` for 20 ticks -> `key`=10, one pulse, `time_button` high until 3 ticks after release, buffer unchanged. Repeat with `#` -> `alarm_button` behaves the same way.
5. Multi-key cases:
   - Two rows in one column -> ignored.
   - Hold `4`, then also press `6` -> exactly one pulse; after both are released, `6` alone is accepted.
6. Assert `reset` mid-DEBOUNCE and mid-PRESSED -> immediate reset values, no pulse; normal scanning resumes after release.
